hazard_scoreboard: RTL and testbench

- Parametrised hazard unit for the in-order MIPS pipeline. Successor to the fixed five-stage stall/forward unit.
- Holds its own per-stage producer records (write address plus remaining Tnew) for NSTAGE stages after D, so no external Tnew register is needed.
- Adds an internal multiply/divide busy counter and a flush-to-bubble path.
- Outputs stall for F/D and forwarding selects for the D-stage and E-stage operands.

---
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - parametrised stall/forward unit with MD busy tracking
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int TW      = 2,
  parameter int CW      = 4,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int SW      = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          d_valid,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [4:0]    d_wra,
  input  logic [TW-1:0] d_tnew,
  input  logic [1:0]    d_md_op,
  input  logic          flush,
  input  logic [4:0]    e_rs,
  input  logic [4:0]    e_rt,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_d,
  output logic [SW-1:0] fwd_rt_d,
  output logic [SW-1:0] fwd_rs_e,
  output logic [SW-1:0] fwd_rt_e,
  output logic          md_busy
);

  // MD operation classes carried on d_md_op
  localparam logic [1:0] MD_NONE = 2'd0;
  localparam logic [1:0] MD_MUL  = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;

  // Producer records: index 1 is E, index NSTAGE is the last tracked stage
  logic [NSTAGE:1][4:0]    wra_q;
  logic [NSTAGE:1][TW-1:0] tnew_q;
  logic [CW-1:0]           md_cnt;

  logic issue;
  logic stall_data;
  logic stall_md;

  // True when src depends on a producer whose result is still later than the
  // consumer can tolerate; register 0 is never a dependency.
  function automatic logic data_hit(
    input logic [4:0]              src,
    input logic [TW-1:0]           tuse,
    input logic [NSTAGE:1][4:0]    wra,
    input logic [NSTAGE:1][TW-1:0] tnew
  );
    logic h;
    h = 1'b0;
    for (int s = 1; s <= NSTAGE; s++) begin
      if ((src != 5'd0) && (src == wra[s]) && (tnew[s] > tuse)) begin
        h = 1'b1;
      end
    end
    return h;
  endfunction

  // Nearest matching producer at or beyond stage 'first'. A nearer producer
  // that is not ready shadows any older match, so the select falls back to 0
  // rather than forwarding a stale value.
  function automatic logic [SW-1:0] fwd_pick(
    input logic [4:0]              src,
    input int                      first,
    input logic [NSTAGE:1][4:0]    wra,
    input logic [NSTAGE:1][TW-1:0] tnew
  );
    logic [SW-1:0] sel;
    logic          found;
    sel   = '0;
    found = 1'b0;
    for (int s = 1; s <= NSTAGE; s++) begin
      if ((s >= first) && !found && (src != 5'd0) && (src == wra[s])) begin
        found = 1'b1;
        if (tnew[s] == '0) begin
          sel = SW'(s);
        end
      end
    end
    return sel;
  endfunction

  // Tnew countdown that holds at zero once the result exists
  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Stall decision from current records, MD counter and D inputs
  always_comb begin
    stall_data = 1'b0;
    stall_md   = 1'b0;
    if (d_valid) begin
      stall_data = data_hit(d_rs, d_tuse_rs, wra_q, tnew_q) |
                   data_hit(d_rt, d_tuse_rt, wra_q, tnew_q);
      stall_md   = (d_md_op != MD_NONE) && (md_cnt != '0);
    end
  end

  assign stall   = stall_data | stall_md;
  assign issue   = d_valid & ~stall & ~flush;
  assign md_busy = (md_cnt != '0);

  // Forward selects: D scans from E onward, E scans from the stage after it
  always_comb begin
    fwd_rs_d = fwd_pick(d_rs, 1, wra_q, tnew_q);
    fwd_rt_d = fwd_pick(d_rt, 1, wra_q, tnew_q);
    fwd_rs_e = fwd_pick(e_rs, 2, wra_q, tnew_q);
    fwd_rt_e = fwd_pick(e_rt, 2, wra_q, tnew_q);
  end

  // Producer record shift: bubble on stall/flush, age Tnew as records advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wra_q  <= '0;
      tnew_q <= '0;
    end else begin
      wra_q[1]  <= issue ? d_wra  : 5'd0;
      tnew_q[1] <= issue ? d_tnew : '0;
      for (int s = 2; s <= NSTAGE; s++) begin
        wra_q[s]  <= wra_q[s-1];
        tnew_q[s] <= dec_sat(tnew_q[s-1]);
      end
    end
  end

  // MD busy counter: a new mult/div load wins over the running countdown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (issue && (d_md_op == MD_MUL)) begin
      md_cnt <= CW'(MUL_LAT);
    end else if (issue && (d_md_op == MD_DIV)) begin
      md_cnt <= CW'(DIV_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       d_valid;
  logic [4:0] d_rs, d_rt;
  logic [1:0] d_tuse_rs, d_tuse_rt;
  logic [4:0] d_wra;
  logic [1:0] d_tnew;
  logic [1:0] d_md_op;
  logic       flush;
  logic [4:0] e_rs, e_rt;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       md_busy;
  logic [9:0] obs;

  int n_checks;
  int n_err;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];

  hazard_scoreboard dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_wra     (d_wra),
    .d_tnew    (d_tnew),
    .d_md_op   (d_md_op),
    .flush     (flush),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .stall     (stall),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .md_busy   (md_busy)
  );

  assign obs = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, md_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ev(input int st, input int rsd, input int rtd,
                                    input int rse, input int rte, input int busy);
    logic [9:0] r;
    r = {st[0], rsd[1:0], rtd[1:0], rse[1:0], rte[1:0], busy[0]};
    return r;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, {22'd0, obs}, {22'd0, e.v});
    end
  endtask

  // One D cycle: drive after the edge, queue the expectation, compare at negedge
  task automatic cyc(input string tag, input logic v,
                     input logic [4:0] rs, input logic [1:0] tur,
                     input logic [4:0] rt, input logic [1:0] tut,
                     input logic [4:0] wra, input logic [1:0] tn,
                     input logic [1:0] md, input logic fl,
                     input logic [4:0] ers, input logic [4:0] ert,
                     input logic [9:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    d_valid = v;  d_rs = rs; d_tuse_rs = tur; d_rt = rt; d_tuse_rt = tut;
    d_wra = wra;  d_tnew = tn; d_md_op = md; flush = fl; e_rs = ers; e_rt = ert;
    e.tag = tag;
    e.v   = expv;
    sb.push_back(e);
    @(negedge clk);
    pop_check();
  endtask

  task automatic idle(input string tag, input logic [9:0] expv);
    cyc(tag, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 5'd0, expv);
  endtask

  initial begin
    exp_t e;
    n_checks = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0;
    d_wra = 0; d_tnew = 0; d_md_op = 0; flush = 0; e_rs = 0; e_rt = 0;

    @(negedge clk);
    e.tag = "reset"; e.v = ev(0, 0, 0, 0, 0, 0); sb.push_back(e);
    pop_check();
    reset_n = 1'b1;

    // load-use: lw r5 then add consuming r5 one cycle later
    cyc("t1_lw",    1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd5, 2'd2, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t1_stall", 1, 5'd5, 2'd1, 5'd0, 2'd0, 5'd6, 2'd1, 2'd0, 0, 5'd0, 5'd0, ev(1, 0, 0, 0, 0, 0));
    cyc("t1_issue", 1, 5'd5, 2'd1, 5'd0, 2'd0, 5'd6, 2'd1, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t1_fwd_e", 0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd5, 5'd0, ev(0, 0, 0, 3, 0, 0));
    for (int i = 0; i < 3; i++) idle("t1_drain", ev(0, 0, 0, 0, 0, 0));

    // branch right after an ALU producer
    cyc("t2_add",   1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd4, 2'd1, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t2_stall", 1, 5'd4, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd0, 5'd0, ev(1, 0, 0, 0, 0, 0));
    cyc("t2_fwd",   1, 5'd4, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd0, 5'd0, ev(0, 2, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) idle("t2_drain", ev(0, 0, 0, 0, 0, 0));

    // nearest producer wins even when it is not ready
    cyc("t3_w0",   1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd3, 2'd0, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t3_w1",   1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd3, 2'd1, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t3_near", 1, 5'd3, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd3, 5'd0, ev(0, 0, 0, 2, 0, 0));
    cyc("t3_rt",   1, 5'd0, 2'd0, 5'd3, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd0, 5'd3, ev(0, 0, 2, 0, 2, 0));
    for (int i = 0; i < 3; i++) idle("t3_drain", ev(0, 0, 0, 0, 0, 0));

    // mult then mfhi: held for the full multiply latency
    cyc("t4_mult", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd1, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      cyc("t4_md_stall", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd3, 0, 5'd0, 5'd0, ev(1, 0, 0, 0, 0, 1));
    cyc("t4_md_free", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd3, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t4_div",     1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd2, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      logic fl;
      fl = (i == 3 || i == 4);
      cyc("t4_div_busy", 0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, fl, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 1));
    end
    idle("t4_div_done", ev(0, 0, 0, 0, 0, 0));

    // register 0 producer/consumer, then a flushed mult with a live destination
    cyc("t5_r0_prod", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd2, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t5_r0_cons", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t5_flush",   1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd9, 2'd2, 2'd1, 1, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t5_after",   1, 5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd3, 0, 5'd9, 5'd0, ev(0, 0, 0, 0, 0, 0));

    // reset while md_cnt=7 and records are live
    cyc("t6_div",  1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd7, 2'd2, 2'd2, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t6_prod", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd7, 2'd2, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 1));
    cyc("t6_fill", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 1));
    cyc("t6_fill", 1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 1));
    cyc("t6_live", 1, 5'd7, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0, 2'd3, 0, 5'd7, 5'd7, ev(1, 3, 3, 3, 3, 1));
    #2;
    reset_n = 1'b0;
    #1;
    e.tag = "t6_async"; e.v = ev(0, 0, 0, 0, 0, 0); sb.push_back(e);
    pop_check();
    #1;
    reset_n = 1'b1;
    cyc("t6_cold_lw",  1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd5, 2'd2, 2'd0, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));
    cyc("t6_cold_use", 1, 5'd5, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'd3, 0, 5'd0, 5'd0, ev(1, 0, 0, 0, 0, 0));
    cyc("t6_cold_go",  1, 5'd5, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 2'd3, 0, 5'd0, 5'd0, ev(0, 0, 0, 0, 0, 0));

    check("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
